// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state and master id constants, response tag type and the
// round-robin grant helper shared by the arbiter.
package mem_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } tag_t;

    // A lone requester always wins; on contention the priority holder wins.
    function automatic logic pick_master(input logic v0, input logic v1, input logic prio);
        return (v0 & v1) ? prio : (v1 ? MASTER1 : MASTER0);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port synchronous memory between
// two masters, with incrementing read bursts and fixed 2-cycle response latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [LEN_WIDTH-1:0]  m0_len,
    input  logic [DATA_WIDTH-1:0] m0_data,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rlast,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [LEN_WIDTH-1:0]  m1_len,
    input  logic [DATA_WIDTH-1:0] m1_data,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rlast,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    logic                  state;
    logic                  prio;
    logic [LEN_WIDTH-1:0]  remaining;
    tag_t                  s1;
    tag_t                  s2;

    logic                  idle;
    logic                  grant;
    logic                  handshake;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic                  last_beat;

    always_comb begin
        idle      = (state == ST_IDLE);
        grant     = pick_master(m0_valid, m1_valid, prio);
        handshake = idle & (m0_valid | m1_valid);
        m0_ready  = idle & m0_valid & (grant == MASTER0);
        m1_ready  = idle & m1_valid & (grant == MASTER1);
        sel_we    = (grant == MASTER1) ? m1_we   : m0_we;
        sel_addr  = (grant == MASTER1) ? m1_addr : m0_addr;
        sel_data  = (grant == MASTER1) ? m1_data : m0_data;
        sel_len   = (grant == MASTER1) ? m1_len  : m0_len;
        last_beat = (remaining == LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prio      <= MASTER0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            s1        <= '0;
            s2        <= '0;
        end else begin
            s2 <= s1;
            if (state == ST_BURST) begin
                mem_we    <= 1'b0;
                mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_WIDTH'(1);
                s1.valid  <= 1'b1;
                s1.last   <= last_beat;
                if (last_beat)
                    state <= ST_IDLE;
            end else if (handshake) begin
                mem_we   <= sel_we;
                mem_addr <= sel_addr;
                mem_data <= sel_data;
                prio     <= ~grant;
                s1       <= '{valid: 1'b1, id: grant, last: sel_we | (sel_len == '0)};
                if (!sel_we && sel_len != '0) begin
                    remaining <= sel_len;
                    state     <= ST_BURST;
                end
            end else begin
                // Idle cycle: drop we so a write is never presented twice.
                mem_we   <= 1'b0;
                s1.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        m0_rvalid = s2.valid & (s2.id == MASTER0);
        m1_rvalid = s2.valid & (s2.id == MASTER1);
        m0_rlast  = m0_rvalid & s2.last;
        m1_rlast  = m1_rvalid & s2.last;
        m0_rdata  = mem_out;
        m1_rdata  = mem_out;
    end

endmodule
